icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
Parametrised set-associative instruction cache between IFetch and memctrl. It supersedes the direct-mapped, one-word-per-line icache.
- Multi-word lines, filled one word per memctrl beat.
- Configurable ways with round-robin replacement.
- Flush input for fence.i and self-modifying code.
- Hit path stays combinational, so IFetch sees same-cycle hits.

Parameters:
ADDR_WIDTH, 32, byte address width
WAYS, 2, associativity; power of 2, range 1..8
SETS, 64, sets per way; power of 2
LINE_WORDS, 4, 32-bit words per line; power of 2, range 1..16

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low freezes all sequential state
fetch_req  in  1  IFetch presents a valid pc
pc  in  ADDR_WIDTH  fetch address, word-aligned
hit  out  1  combinational: pc present in cache
inst_out  out  32  combinational: hit word; don't-care when hit=0
flush  in  1  invalidate whole cache
mem_req  out  1  word request to memctrl
mem_addr  out  ADDR_WIDTH  requested word address
mem_vld  in  1  memctrl beat valid
mem_data  in  32  beat data

Behaviour:
Address split:
- OFF = 2 + log2(LINE_WORDS)
- index = pc[OFF+log2(SETS)-1 : OFF]
- word = pc[OFF-1 : 2]
- tag = remaining upper bits

Hit and output:
- hit = OR over ways of (valid & tag match), independent of state and fetch_req.
- inst_out = data of the matching way at the selected word.
- A line is never visible to hit before its final beat is written.

Reset (rst low, async):
- state = IDLE; mem_req = 0; mem_addr = 0; fill counter = 0.
- All valid bits = 0; all victim pointers = 0.
- Tag and data arrays are not reset.
- Reset asserted mid-fill abandons the fill immediately.

rdy low:
- No state, counter, array or pointer change.
- mem_vld is ignored.
- Outputs hold their values.

State IDLE:
- Condition: rdy & fetch_req & !hit & !flush.
- Action: latch line base = {tag, index, word 0} and fill_set = index.
- Choose victim: the lowest-numbered invalid way in the set; if none is invalid, the set's victim pointer.
- Next cycle: mem_req = 1, mem_addr = line base, cnt = 0; go to FILL.

State FILL:
- mem_req and mem_addr stay stable until mem_vld.
- On each edge with mem_vld: write mem_data to data[victim][fill_set][cnt]; cnt++; mem_addr += 4.
- On the last beat (cnt = LINE_WORDS-1):
  - write the tag and set valid for the victim way;
  - if the victim came from the pointer, the pointer advances modulo WAYS;
  - mem_req drops to 0 on the same edge; go to IDLE.
- Fill latency: 1 + LINE_WORDS x (memctrl beat latency) cycles from miss to hit.
- pc changes during FILL do not affect the fill in progress. hit keeps evaluating the current pc and may be 1 for other resident lines.
- No second miss is issued while in FILL.

Flush:
- flush high (with rdy) clears every valid bit on that edge.
- In FILL: abort; mem_req = 0 next cycle; go to IDLE; the partial line stays invalid.
- Memctrl treats mem_req falling as cancel.
- Simultaneous flush and last beat: flush wins, line invalid.
- Simultaneous flush and miss in IDLE: no fill starts.

Other:
- mem_vld while in IDLE is ignored.
- WAYS=1 degenerates to direct-mapped; the pointer logic is unused.

Test Plan:
1. Reset values (WAYS=2, SETS=64, LINE_WORDS=4): pulse rst low mid-cycle -> mem_req=0 and hit=0 immediately, with no clock edge needed.
2. Cold miss, one-cycle beats: fetch_req with pc=0x1008 -> mem_addr 0x1000, 0x1004, 0x1008, 0x100C on consecutive beats, mem_req drops after the 4th. Then pc=0x1000..0x100C all hit with the supplied data; pc=0x1010 misses.
3. Replacement: fill 0x0000, 0x0400 and 0x0800 (all set 0) -> after the third fill, 0x0000 misses and 0x0400/0x0800 hit. A fourth fill of 0x0C00 evicts 0x0400 (pointer=1).
4. Flush mid-fill: assert flush after the 2nd beat -> mem_req=0 next cycle, state IDLE. A third mem_vld is ignored; 0x1000 misses; previously resident lines miss.
5. rdy stall: hold rdy low for 5 cycles during FILL while toggling mem_vld -> cnt and mem_addr unchanged. The fill resumes and completes correctly after rdy returns high.
6. Last-beat/flush collision: flush on the same edge as the 4th beat -> line invalid, hit=0, state IDLE.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word lines, round-robin replacement
// and whole-cache flush. Hits are combinational; misses fill one word per memctrl beat.
module icache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  hit,
  output logic [31:0]           inst_out,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_vld,
  input  logic [31:0]           mem_data
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int IB  = $clog2(SETS);
  localparam int OFF = 2 + WB;
  localparam int TW  = ADDR_WIDTH - OFF - IB;
  localparam int CW  = (WB > 0) ? WB : 1;
  localparam int IW  = (IB > 0) ? IB : 1;
  localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_fill_tag;
  logic [IW-1:0]   r_fill_set;
  logic [AW-1:0]   r_victim;
  logic            r_from_ptr;
  logic [CW-1:0]   r_cnt;

  logic [WAYS-1:0] r_valid [SETS];
  logic [AW-1:0]   r_ptr   [SETS];
  logic [TW-1:0]   r_tag   [WAYS][SETS];
  logic [31:0]     r_data  [WAYS][SETS][LINE_WORDS];

  logic [CW-1:0]         w_word;
  logic [IW-1:0]         w_index;
  logic [TW-1:0]         w_tag;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_hit;
  logic [31:0]           w_inst;
  logic [AW-1:0]         w_victim;
  logic                  w_from_ptr;
  logic                  w_last;

  assign w_word  = CW'((pc >> 2) & ADDR_WIDTH'(LINE_WORDS - 1));
  assign w_index = IW'((pc >> OFF) & ADDR_WIDTH'(SETS - 1));
  assign w_tag   = TW'(pc >> (OFF + IB));
  assign w_base  = pc & ~ADDR_WIDTH'((1 << OFF) - 1);
  assign w_last  = (r_cnt == CW'(LINE_WORDS - 1));

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_hit  = 1'b0;
    w_inst = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_index][w] && (r_tag[w][w_index] == w_tag)) begin
        w_hit  = 1'b1;
        w_inst = r_data[w][w_index][w_word];
      end
    end
  end

  assign hit      = w_hit;
  assign inst_out = w_inst;

  // Descending scan leaves the lowest-numbered invalid way; pointer only when the set is full.
  always_comb begin
    w_victim   = r_ptr[w_index];
    w_from_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_index][w]) begin
        w_victim   = AW'(w);
        w_from_ptr = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      r_cnt      <= '0;
      r_fill_tag <= '0;
      r_fill_set <= '0;
      r_victim   <= '0;
      r_from_ptr <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (fetch_req && !w_hit && !flush) begin
            r_fill_tag <= w_tag;
            r_fill_set <= w_index;
            r_victim   <= w_victim;
            r_from_ptr <= w_from_ptr;
            // The victim's old contents are overwritten beat by beat, so hide it now.
            r_valid[w_index][w_victim] <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= w_base;
            r_cnt      <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) begin
            mem_req <= 1'b0;
            r_state <= S_IDLE;
          end else if (mem_vld) begin
            r_cnt    <= CW'(r_cnt + 1'b1);
            mem_addr <= mem_addr + ADDR_WIDTH'(4);
            if (w_last) begin
              r_valid[r_fill_set][r_victim] <= 1'b1;
              if (r_from_ptr) begin
                r_ptr[r_fill_set] <= (r_ptr[r_fill_set] == AW'(WAYS - 1)) ? '0
                                   : AW'(r_ptr[r_fill_set] + 1'b1);
              end
              mem_req <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (rdy && (r_state == S_FILL) && mem_vld && !flush) begin
      r_data[r_victim][r_fill_set][r_cnt] <= mem_data;
      if (w_last) r_tag[r_victim][r_fill_set] <= r_fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: miss/fill sequencing, replacement, flush,
// rdy stalls and asynchronous reset, with lookups driven from a vector table.
module tb_icache_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] pc;
  logic        hit;
  logic [31:0] inst_out;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_vld;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  icache_assoc #(.ADDR_WIDTH(32), .WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .fetch_req (fetch_req),
    .pc        (pc),
    .hit       (hit),
    .inst_out  (inst_out),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_vld   (mem_vld),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    logic [31:0] addr;
    logic        exp_hit;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_phase(input int p);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].phase == p) begin
        pc        = vecs[i].addr;
        fetch_req = 1'b0;
        #1;
        check($sformatf("p%0d hit @%08h", p, vecs[i].addr), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
        if (vecs[i].exp_hit)
          check($sformatf("p%0d inst @%08h", p, vecs[i].addr), inst_out, model(vecs[i].addr));
        @(negedge clk);
      end
    end
  endtask

  task automatic start_miss(input logic [31:0] a);
    pc        = a;
    fetch_req = 1'b1;
    #1;
    check($sformatf("miss hit=0 @%08h", a), {31'd0, hit}, 32'd0);
    @(negedge clk);
    fetch_req = 1'b0;
    check($sformatf("miss mem_req @%08h", a), {31'd0, mem_req}, 32'd1);
    check($sformatf("miss base @%08h", a), mem_addr, a & ~32'hF);
  endtask

  task automatic beat(input logic [31:0] exp_addr);
    check($sformatf("beat addr %08h", exp_addr), mem_addr, exp_addr);
    check($sformatf("beat req %08h", exp_addr), {31'd0, mem_req}, 32'd1);
    mem_vld  = 1'b1;
    mem_data = model(exp_addr);
    @(negedge clk);
    mem_vld  = 1'b0;
  endtask

  task automatic full_fill(input logic [31:0] a);
    start_miss(a);
    for (int i = 0; i < 4; i++) beat((a & ~32'hF) + 32'(4 * i));
    check($sformatf("req drop %08h", a), {31'd0, mem_req}, 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{1, 32'h0000_1000, 1'b1}, '{1, 32'h0000_1004, 1'b1}, '{1, 32'h0000_1008, 1'b1},
      '{1, 32'h0000_100C, 1'b1}, '{1, 32'h0000_1010, 1'b0},
      '{2, 32'h0000_0000, 1'b0}, '{2, 32'h0000_0404, 1'b1}, '{2, 32'h0000_0808, 1'b1},
      '{3, 32'h0000_0400, 1'b0}, '{3, 32'h0000_0800, 1'b1}, '{3, 32'h0000_0C0C, 1'b1},
      '{4, 32'h0000_1000, 1'b0}, '{4, 32'h0000_0C00, 1'b0}, '{4, 32'h0000_0800, 1'b0},
      '{5, 32'h0000_2000, 1'b1}, '{5, 32'h0000_2004, 1'b1}, '{5, 32'h0000_2008, 1'b1},
      '{5, 32'h0000_200C, 1'b1},
      '{6, 32'h0000_3000, 1'b0}, '{6, 32'h0000_3008, 1'b0}, '{6, 32'h0000_2000, 1'b0},
      '{7, 32'h0000_3000, 1'b1}, '{7, 32'h0000_3004, 1'b1}, '{7, 32'h0000_3008, 1'b1},
      '{7, 32'h0000_300C, 1'b1}
    };

    rst = 1'b0; rdy = 1'b1; fetch_req = 1'b0; pc = '0;
    flush = 1'b0; mem_vld = 1'b0; mem_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset hit", {31'd0, hit}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss with back-to-back beats, critical word in the middle of the line.
    full_fill(32'h0000_1008);
    apply_phase(1);

    // Three lines into set 0, then a fourth: round-robin eviction.
    pulse_flush();
    full_fill(32'h0000_0000);
    full_fill(32'h0000_0400);
    full_fill(32'h0000_0800);
    apply_phase(2);
    full_fill(32'h0000_0C00);
    apply_phase(3);

    // Flush after two beats: fill abandoned, late beat ignored.
    start_miss(32'h0000_1000);
    beat(32'h0000_1000);
    beat(32'h0000_1004);
    pulse_flush();
    check("flush req drop", {31'd0, mem_req}, 32'd0);
    mem_vld  = 1'b1;
    mem_data = model(32'h0000_1008);
    @(negedge clk);
    mem_vld  = 1'b0;
    check("idle vld req", {31'd0, mem_req}, 32'd0);
    check("idle vld addr", mem_addr, 32'h0000_1008);
    apply_phase(4);
    start_miss(32'h0000_1000);
    pulse_flush();
    check("flush cancel req", {31'd0, mem_req}, 32'd0);

    // rdy stall mid-fill with mem_vld toggling.
    start_miss(32'h0000_2000);
    beat(32'h0000_2000);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_vld  = (i % 2 == 0);
      mem_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check($sformatf("stall %0d addr", i), mem_addr, 32'h0000_2004);
      check($sformatf("stall %0d req", i), {31'd0, mem_req}, 32'd1);
    end
    mem_vld = 1'b0;
    rdy     = 1'b1;
    beat(32'h0000_2004);
    beat(32'h0000_2008);
    beat(32'h0000_200C);
    check("stall fill done", {31'd0, mem_req}, 32'd0);
    apply_phase(5);

    // Flush on the same edge as the final beat.
    start_miss(32'h0000_3000);
    beat(32'h0000_3000);
    beat(32'h0000_3004);
    beat(32'h0000_3008);
    check("collide addr", mem_addr, 32'h0000_300C);
    mem_vld  = 1'b1;
    mem_data = model(32'h0000_300C);
    flush    = 1'b1;
    @(negedge clk);
    mem_vld  = 1'b0;
    flush    = 1'b0;
    check("collide req", {31'd0, mem_req}, 32'd0);
    apply_phase(6);
    full_fill(32'h0000_3000);
    apply_phase(7);

    // Asynchronous reset mid-cycle during a fill.
    start_miss(32'h0000_4000);
    pc = 32'h0000_3004;
    #1;
    check("pre-reset hit", {31'd0, hit}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async rst mem_req", {31'd0, mem_req}, 32'd0);
    check("async rst hit", {31'd0, hit}, 32'd0);
    check("async rst mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset req", {31'd0, mem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
